perf_counter_unit: RTL and testbench

//   Event-counting front end for the performance monitor. Converts per-cycle pipeline event strobes
//   (retire, stall, branch, hazard, memory, instruction type) into 32-bit saturating running counts,

---
 rtl/perf_counter_unit.sv | 218 +++++++++++++++++++++
 tb/tb_perf_counter_unit.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/perf_counter_unit.sv
// perf_counter_unit: saturating 32-bit pipeline event counters, per-type retire bins,
// fixed-length measurement window with per-window delta snapshot and valid/ready handoff.
`default_nettype none

module perf_counter_unit #(
    parameter int WINDOW_SIZE = 1000,
    parameter int NUM_TYPES   = 6,
    parameter int TYPE_W      = 3
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        enable_i,
    input  logic                        clear_i,
    input  logic                        instr_retire_i,
    input  logic [TYPE_W-1:0]           instr_type_i,
    input  logic                        stall_i,
    input  logic                        branch_resolved_i,
    input  logic                        branch_mispredict_i,
    input  logic                        hazard_detected_i,
    input  logic                        mem_access_i,
    output logic [31:0]                 cycle_count_o,
    output logic [31:0]                 instruction_count_o,
    output logic [31:0]                 stall_count_o,
    output logic [31:0]                 branch_count_o,
    output logic [31:0]                 branch_mispredict_count_o,
    output logic [31:0]                 hazard_count_o,
    output logic [31:0]                 memory_access_count_o,
    output logic [NUM_TYPES-1:0][31:0]  instruction_type_counts_o,
    output logic [6:0]                  sat_flags_o,
    output logic [NUM_TYPES-1:0]        type_sat_o,
    output logic                        window_tick_o,
    output logic                        snap_valid_o,
    input  logic                        snap_ready_i,
    output logic [31:0]                 snap_instr_o,
    output logic [31:0]                 snap_stall_o,
    output logic [31:0]                 snap_mispredict_o,
    output logic                        snap_overrun_o
);

    localparam int              WIN_W    = (WINDOW_SIZE > 1) ? $clog2(WINDOW_SIZE) : 1;
    localparam logic [31:0]     CNT_MAX  = 32'hFFFF_FFFF;
    localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(WINDOW_SIZE - 1);

    function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic inc);
        if (inc && (v != CNT_MAX)) begin
            return v + 32'd1;
        end
        return v;
    endfunction

    // Event totals
    logic [31:0] cyc_q, instr_q, stall_q, br_q, mispr_q, haz_q, mem_q;
    logic [6:0]  sat_q, sat_d;
    logic [6:0][31:0] evt_cur, evt_d;
    logic [6:0]  evt_hit;

    // Type bins
    logic [NUM_TYPES-1:0][31:0] type_q, type_d;
    logic [NUM_TYPES-1:0]       type_sat_q, type_sat_d;

    // Window and snapshot
    logic [WIN_W-1:0] win_q, win_d;
    logic             tick_q, tick_d;
    logic             wrap;
    logic [31:0]      acc_instr_q, acc_instr_d, acc_stall_q, acc_stall_d, acc_mispr_q, acc_mispr_d;
    logic [31:0]      win_instr, win_stall, win_mispr;
    logic             snap_valid_q, snap_valid_d, snap_overrun_q, snap_overrun_d;
    logic [31:0]      snap_instr_q, snap_instr_d, snap_stall_q, snap_stall_d, snap_mispr_q, snap_mispr_d;
    logic             mispr_evt;

    assign mispr_evt = branch_resolved_i & branch_mispredict_i;

    // Bit order matches sat_flags: cyc, instr, stall, br, mispr, haz, mem.
    assign evt_hit = {mem_access_i, hazard_detected_i, mispr_evt, branch_resolved_i,
                      stall_i, instr_retire_i, 1'b1};
    assign evt_cur = {mem_q, haz_q, mispr_q, br_q, stall_q, instr_q, cyc_q};

    always_comb begin
        evt_d = evt_cur;
        sat_d = sat_q;
        for (int i = 0; i < 7; i++) begin
            if (enable_i && evt_hit[i]) begin
                if (evt_cur[i] == CNT_MAX) begin
                    sat_d[i] = 1'b1;
                end else begin
                    evt_d[i] = evt_cur[i] + 32'd1;
                end
            end
        end
    end

    // Out-of-range types never match any bin, so they are silently ignored.
    always_comb begin
        type_d     = type_q;
        type_sat_d = type_sat_q;
        for (int t = 0; t < NUM_TYPES; t++) begin
            if (enable_i && instr_retire_i && (instr_type_i == TYPE_W'(t))) begin
                if (type_q[t] == CNT_MAX) begin
                    type_sat_d[t] = 1'b1;
                end else begin
                    type_d[t] = type_q[t] + 32'd1;
                end
            end
        end
    end

    assign wrap      = enable_i && (win_q == WIN_LAST);
    assign win_instr = sat_inc(acc_instr_q, instr_retire_i);
    assign win_stall = sat_inc(acc_stall_q, stall_i);
    assign win_mispr = sat_inc(acc_mispr_q, mispr_evt);

    always_comb begin
        win_d          = win_q;
        tick_d         = wrap;
        acc_instr_d    = acc_instr_q;
        acc_stall_d    = acc_stall_q;
        acc_mispr_d    = acc_mispr_q;
        snap_valid_d   = snap_valid_q;
        snap_overrun_d = snap_overrun_q;
        snap_instr_d   = snap_instr_q;
        snap_stall_d   = snap_stall_q;
        snap_mispr_d   = snap_mispr_q;

        if (enable_i) begin
            if (wrap) begin
                win_d       = '0;
                acc_instr_d = '0;
                acc_stall_d = '0;
                acc_mispr_d = '0;
            end else begin
                win_d       = win_q + 1'b1;
                acc_instr_d = win_instr;
                acc_stall_d = win_stall;
                acc_mispr_d = win_mispr;
            end
        end

        // The wrap-cycle events belong to the window that is closing.
        if (wrap) begin
            if (!snap_valid_q || snap_ready_i) begin
                snap_valid_d = 1'b1;
                snap_instr_d = win_instr;
                snap_stall_d = win_stall;
                snap_mispr_d = win_mispr;
            end else begin
                snap_overrun_d = 1'b1;
            end
        end else if (snap_valid_q && snap_ready_i) begin
            snap_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset || clear_i) begin
            cyc_q          <= '0;
            instr_q        <= '0;
            stall_q        <= '0;
            br_q           <= '0;
            mispr_q        <= '0;
            haz_q          <= '0;
            mem_q          <= '0;
            sat_q          <= '0;
            type_q         <= '0;
            type_sat_q     <= '0;
            win_q          <= '0;
            tick_q         <= 1'b0;
            acc_instr_q    <= '0;
            acc_stall_q    <= '0;
            acc_mispr_q    <= '0;
            snap_valid_q   <= 1'b0;
            snap_overrun_q <= 1'b0;
            snap_instr_q   <= '0;
            snap_stall_q   <= '0;
            snap_mispr_q   <= '0;
        end else begin
            cyc_q          <= evt_d[0];
            instr_q        <= evt_d[1];
            stall_q        <= evt_d[2];
            br_q           <= evt_d[3];
            mispr_q        <= evt_d[4];
            haz_q          <= evt_d[5];
            mem_q          <= evt_d[6];
            sat_q          <= sat_d;
            type_q         <= type_d;
            type_sat_q     <= type_sat_d;
            win_q          <= win_d;
            tick_q         <= tick_d;
            acc_instr_q    <= acc_instr_d;
            acc_stall_q    <= acc_stall_d;
            acc_mispr_q    <= acc_mispr_d;
            snap_valid_q   <= snap_valid_d;
            snap_overrun_q <= snap_overrun_d;
            snap_instr_q   <= snap_instr_d;
            snap_stall_q   <= snap_stall_d;
            snap_mispr_q   <= snap_mispr_d;
        end
    end

    assign cycle_count_o             = cyc_q;
    assign instruction_count_o       = instr_q;
    assign stall_count_o             = stall_q;
    assign branch_count_o            = br_q;
    assign branch_mispredict_count_o = mispr_q;
    assign hazard_count_o            = haz_q;
    assign memory_access_count_o     = mem_q;
    assign instruction_type_counts_o = type_q;
    assign sat_flags_o               = sat_q;
    assign type_sat_o                = type_sat_q;
    assign window_tick_o             = tick_q;
    assign snap_valid_o              = snap_valid_q;
    assign snap_instr_o              = snap_instr_q;
    assign snap_stall_o              = snap_stall_q;
    assign snap_mispredict_o         = snap_mispr_q;
    assign snap_overrun_o            = snap_overrun_q;

endmodule

`default_nettype wire

// File: tb/tb_perf_counter_unit.sv
// Directed bench for perf_counter_unit with an 8-cycle window.
`default_nettype none

module tb_perf_counter_unit;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              enable_i = 1'b0, clear_i = 1'b0;
    logic              instr_retire_i = 1'b0;
    logic [2:0]        instr_type_i = '0;
    logic              stall_i = 1'b0, branch_resolved_i = 1'b0, branch_mispredict_i = 1'b0;
    logic              hazard_detected_i = 1'b0, mem_access_i = 1'b0, snap_ready_i = 1'b0;
    logic [31:0]       cyc, instr, stl, br, mis, haz, mem, s_instr, s_stall, s_mis;
    logic [5:0][31:0]  tcnt;
    logic [6:0]        sat;
    logic [5:0]        tsat;
    logic              tick, s_valid, s_over;

    int n_assert = 0;
    int n_fail   = 0;

    perf_counter_unit #(.WINDOW_SIZE(8), .NUM_TYPES(6), .TYPE_W(3)) dut (
        .clk(clk), .reset(reset), .enable_i(enable_i), .clear_i(clear_i),
        .instr_retire_i(instr_retire_i), .instr_type_i(instr_type_i), .stall_i(stall_i),
        .branch_resolved_i(branch_resolved_i), .branch_mispredict_i(branch_mispredict_i),
        .hazard_detected_i(hazard_detected_i), .mem_access_i(mem_access_i),
        .cycle_count_o(cyc), .instruction_count_o(instr), .stall_count_o(stl),
        .branch_count_o(br), .branch_mispredict_count_o(mis), .hazard_count_o(haz),
        .memory_access_count_o(mem), .instruction_type_counts_o(tcnt),
        .sat_flags_o(sat), .type_sat_o(tsat), .window_tick_o(tick),
        .snap_valid_o(s_valid), .snap_ready_i(snap_ready_i), .snap_instr_o(s_instr),
        .snap_stall_o(s_stall), .snap_mispredict_o(s_mis), .snap_overrun_o(s_over)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_clear();
        enable_i = 1'b0; clear_i = 1'b1;
        cycles(1);
        clear_i = 1'b0;
    endtask

    initial begin
        // Reset state
        cycles(1);
        chk("rst_cycle", cyc, 32'd0);
        chk("rst_instr", instr, 32'd0);
        chk("rst_sat", {25'd0, sat}, 32'd0);
        chk("rst_valid", {31'd0, s_valid}, 32'd0);
        chk("rst_tick", {31'd0, tick}, 32'd0);
        reset = 1'b0;

        // Count, then asynchronous reset mid-count
        enable_i = 1'b1; instr_retire_i = 1'b1; instr_type_i = 3'd0;
        cycles(3);
        chk("pre_rst_instr", instr, 32'd3);
        chk("pre_rst_bin0", tcnt[0], 32'd3);
        #2 reset = 1'b1;
        #1;
        chk("async_rst_instr", instr, 32'd0);
        chk("async_rst_cycle", cyc, 32'd0);
        chk("async_rst_bin0", tcnt[0], 32'd0);
        @(negedge clk) reset = 1'b0;
        cycles(1);
        chk("resume_instr", instr, 32'd1);

        // Type bins: 20 retires with types 0,1,2,3,4,5,7 repeating
        do_clear();
        chk("clear_instr", instr, 32'd0);
        enable_i = 1'b1; instr_retire_i = 1'b1;
        for (int i = 0; i < 20; i++) begin
            instr_type_i = ((i % 7) == 6) ? 3'd7 : 3'(i % 7);
            cycles(1);
        end
        instr_retire_i = 1'b0;
        chk("types_instr", instr, 32'd20);
        chk("types_cycle", cyc, 32'd20);
        for (int t = 0; t < 6; t++) begin
            chk($sformatf("type_bin%0d", t), tcnt[t], 32'd3);
        end
        chk("type_sat", {26'd0, tsat}, 32'd0);

        // Branch / mispredict gating, hazard and memory events
        do_clear();
        enable_i = 1'b1; branch_mispredict_i = 1'b1; hazard_detected_i = 1'b1;
        cycles(4);
        branch_resolved_i = 1'b1; hazard_detected_i = 1'b0; mem_access_i = 1'b1;
        cycles(2);
        branch_resolved_i = 1'b0; branch_mispredict_i = 1'b0; mem_access_i = 1'b0;
        chk("br_count", br, 32'd2);
        chk("mispr_count", mis, 32'd2);
        chk("haz_count", haz, 32'd4);
        chk("mem_count", mem, 32'd2);

        // Stall counter saturation
        do_clear();
        force dut.stall_q = 32'hFFFF_FFFE;
        #1 release dut.stall_q;
        enable_i = 1'b1; stall_i = 1'b1;
        cycles(1);
        chk("stall_at_max", stl, 32'hFFFF_FFFF);
        chk("sat_not_yet", {25'd0, sat}, 32'd0);
        cycles(2);
        stall_i = 1'b0;
        chk("stall_held", stl, 32'hFFFF_FFFF);
        chk("sat_stall", {25'd0, sat}, 32'h04);
        chk("sat_cycle", cyc, 32'd3);
        do_clear();
        chk("sat_cleared", {25'd0, sat}, 32'd0);

        // Window 1: retires on 1,3,5,7,8; stalls on 2,4,6; mispredict on wrap cycle 8
        enable_i = 1'b1;
        for (int c = 1; c <= 7; c++) begin
            instr_retire_i = (c % 2) == 1;
            stall_i        = (c % 2) == 0;
            cycles(1);
        end
        chk("tick_early", {31'd0, tick}, 32'd0);
        instr_retire_i = 1'b1; stall_i = 1'b0;
        branch_resolved_i = 1'b1; branch_mispredict_i = 1'b1;
        cycles(1);
        branch_resolved_i = 1'b0; branch_mispredict_i = 1'b0;
        chk("tick_w1", {31'd0, tick}, 32'd1);
        chk("valid_w1", {31'd0, s_valid}, 32'd1);
        chk("snap_stall_w1", s_stall, 32'd3);
        chk("snap_instr_w1", s_instr, 32'd5);
        chk("snap_mis_w1", s_mis, 32'd1);
        chk("overrun_w1", {31'd0, s_over}, 32'd0);

        // Window 2 with snap_ready low, one frozen cycle inside
        cycles(1);
        chk("tick_pulse_end", {31'd0, tick}, 32'd0);
        enable_i = 1'b0;
        cycles(1);
        chk("freeze_cycle", cyc, 32'd9);
        enable_i = 1'b1;
        cycles(7);
        chk("overrun_w2", {31'd0, s_over}, 32'd1);
        chk("snap_kept", s_instr, 32'd5);
        chk("valid_w2", {31'd0, s_valid}, 32'd1);
        chk("tick_w2", {31'd0, tick}, 32'd1);
        enable_i = 1'b0; instr_retire_i = 1'b0; snap_ready_i = 1'b1;
        cycles(1);
        snap_ready_i = 1'b0;
        chk("valid_dropped", {31'd0, s_valid}, 32'd0);
        chk("overrun_sticky", {31'd0, s_over}, 32'd1);
        chk("instr_total", instr, 32'd13);

        // Window 3 then clear mid-window
        enable_i = 1'b1;
        cycles(8);
        chk("valid_w3", {31'd0, s_valid}, 32'd1);
        chk("snap_instr_w3", s_instr, 32'd0);
        cycles(3);
        do_clear();
        chk("clr_valid", {31'd0, s_valid}, 32'd0);
        chk("clr_overrun", {31'd0, s_over}, 32'd0);
        chk("clr_cycle", cyc, 32'd0);
        enable_i = 1'b1;
        cycles(7);
        chk("restart_no_tick", {31'd0, tick}, 32'd0);
        cycles(1);
        chk("restart_tick", {31'd0, tick}, 32'd1);
        chk("restart_valid", {31'd0, s_valid}, 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
